// File: rtl/add_node_split_pkg.sv
// rtl/add_node_split_pkg.sv - shared gene field offsets, node types and FSM states for add_node_split
package add_node_split_pkg;

  // Field positions are expressed in units of ATTR_SZ bits.
  localparam int NODE_ID     = 5;
  localparam int NODE_TYPE   = 7;  // type occupies [7*A-2:7*A-3]
  localparam int CONN_SRC    = 5;
  localparam int CONN_DEST   = 4;
  localparam int CONN_EN     = 7;  // enable is the single bit 7*A-1
  localparam int CONN_WEIGHT = 2;  // weight spans two attribute fields

  typedef enum logic [1:0] {
    NODE_HIDDEN = 2'b00,
    NODE_INPUT  = 2'b01,
    NODE_OUTPUT = 2'b10
  } node_type_e;

  typedef enum logic [2:0] {
    PASS,
    EMIT_A,
    EMIT_B,
    FLUSH,
    DONE
  } fsm_e;

endpackage

// File: rtl/add_node_split_if.sv
// rtl/add_node_split_if.sv - gene stream in/out bundle for add_node_split
interface add_node_split_if #(
  parameter int GENE_SZ = 64
);
  logic [GENE_SZ-1:0] gene_in;
  logic               in_valid;
  logic               in_last;
  logic               in_ready;
  logic [GENE_SZ-1:0] gene_out;
  logic               out_valid;
  logic               out_is_node;

  modport master (
    output gene_in, in_valid, in_last,
    input  in_ready, gene_out, out_valid, out_is_node
  );

  modport slave (
    input  gene_in, in_valid, in_last,
    output in_ready, gene_out, out_valid, out_is_node
  );
endinterface

// File: rtl/add_node_split_pending_node_fifo.sv
// rtl/add_node_split_pending_node_fifo.sv - small FIFO of node ids awaiting emission after the connection stream
module pending_node_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr;
  logic [PTR_W-1:0] r_rd;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_clr) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= next_ptr(r_wr);
      if (w_do_pop)  r_rd <= next_ptr(r_rd);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr] <= i_din;
  end

  assign o_dout  = r_mem[r_rd];
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
endmodule

// File: rtl/add_node_split.sv
// rtl/add_node_split.sv - add-node mutation: splits selected connections and appends the new node genes
module add_node_split
  import add_node_split_pkg::*;
#(
  parameter int                   GENE_SZ      = 64,
  parameter int                   ATTR_SZ      = 8,
  parameter int                   LIM_ADD_NODE = 4,
  parameter logic [2*ATTR_SZ-1:0] NEW_WEIGHT   = 16'h0100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_setup,
  input  logic               i_state,
  input  logic [ATTR_SZ-1:0] i_node_add_prob,
  input  logic [ATTR_SZ-1:0] i_random,
  input  logic [ATTR_SZ-1:0] i_next_node_id,
  output logic               o_done,
  add_node_split_if.slave    bus
);
  localparam int ADD_W    = $clog2(LIM_ADD_NODE + 1);
  localparam int EN_BIT   = CONN_EN * ATTR_SZ - 1;
  localparam int TYPE_LSB = NODE_TYPE * ATTR_SZ - 3;

  fsm_e               r_fsm, w_nxt;
  logic [ATTR_SZ-1:0] r_prob;
  logic [ATTR_SZ-1:0] r_node_ctr;
  logic [ADD_W-1:0]   r_add_ctr;
  logic [GENE_SZ-1:0] r_gene;
  logic               r_last_pending;
  logic [GENE_SZ-1:0] r_gene_out, w_gene_out;
  logic               r_out_valid, w_out_valid;
  logic               r_out_is_node, w_out_is_node;
  logic               w_acc, w_split_cond, w_split, w_push, w_pop;
  logic [ATTR_SZ-1:0] w_fifo_dout;
  logic               w_fifo_empty, w_fifo_full;
  logic [ADD_W-1:0]   w_fifo_count;

  assign bus.in_ready = (r_fsm == PASS);
  assign w_acc        = bus.in_valid && bus.in_ready;
  // Id all-ones is reserved, so a saturated node counter blocks further splits.
  assign w_split_cond = (i_random > r_prob) && bus.gene_in[EN_BIT] &&
                        (r_add_ctr < ADD_W'(LIM_ADD_NODE)) && (r_node_ctr != '1);

  always_comb begin
    w_nxt         = r_fsm;
    w_gene_out    = '0;
    w_out_valid   = 1'b0;
    w_out_is_node = 1'b0;
    w_split       = 1'b0;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    case (r_fsm)
      PASS: begin
        if (w_acc) begin
          w_gene_out  = bus.gene_in;
          w_out_valid = 1'b1;
          if (!i_state) begin
            w_out_is_node = 1'b1;
          end else if (w_split_cond) begin
            w_gene_out[EN_BIT] = 1'b0;
            w_split            = 1'b1;
            w_nxt              = EMIT_A;
          end else if (bus.in_last) begin
            w_nxt = FLUSH;
          end
        end
      end
      EMIT_A: begin
        w_gene_out = r_gene;
        w_gene_out[CONN_DEST*ATTR_SZ +: ATTR_SZ]     = r_node_ctr;
        w_gene_out[CONN_WEIGHT*ATTR_SZ +: 2*ATTR_SZ] = NEW_WEIGHT;
        w_gene_out[EN_BIT] = 1'b1;
        w_out_valid        = 1'b1;
        w_nxt              = EMIT_B;
      end
      EMIT_B: begin
        w_gene_out = r_gene;
        w_gene_out[CONN_SRC*ATTR_SZ +: ATTR_SZ] = r_node_ctr;
        w_gene_out[EN_BIT] = 1'b1;
        w_out_valid        = 1'b1;
        w_push             = !w_fifo_full;
        w_nxt              = r_last_pending ? FLUSH : PASS;
      end
      FLUSH: begin
        if (!w_fifo_empty) begin
          w_pop         = 1'b1;
          w_gene_out[NODE_ID*ATTR_SZ +: ATTR_SZ] = w_fifo_dout;
          w_gene_out[TYPE_LSB +: 2]              = NODE_HIDDEN;
          w_out_valid   = 1'b1;
          w_out_is_node = 1'b1;
          if (w_fifo_count == ADD_W'(1)) w_nxt = DONE;
        end else begin
          w_nxt = DONE;
        end
      end
      default: w_nxt = r_fsm;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fsm          <= PASS;
      r_prob         <= '0;
      r_node_ctr     <= '0;
      r_add_ctr      <= '0;
      r_gene         <= '0;
      r_last_pending <= 1'b0;
      r_gene_out     <= '0;
      r_out_valid    <= 1'b0;
      r_out_is_node  <= 1'b0;
    end else if (i_setup) begin
      r_fsm          <= PASS;
      r_prob         <= i_node_add_prob;
      r_node_ctr     <= i_next_node_id;
      r_add_ctr      <= '0;
      r_last_pending <= 1'b0;
      r_gene_out     <= '0;
      r_out_valid    <= 1'b0;
      r_out_is_node  <= 1'b0;
    end else begin
      r_fsm         <= w_nxt;
      r_gene_out    <= w_gene_out;
      r_out_valid   <= w_out_valid;
      r_out_is_node <= w_out_is_node;
      if (w_split) begin
        r_gene         <= bus.gene_in;
        r_last_pending <= bus.in_last;
      end
      if (w_push) begin
        r_node_ctr <= r_node_ctr + 1'b1;
        r_add_ctr  <= r_add_ctr + 1'b1;
      end
    end
  end

  pending_node_fifo #(
    .DEPTH (LIM_ADD_NODE),
    .WIDTH (ATTR_SZ)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (i_setup),
    .i_push  (w_push),
    .i_din   (r_node_ctr),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_count (w_fifo_count)
  );

  assign bus.gene_out    = r_gene_out;
  assign bus.out_valid   = r_out_valid;
  assign bus.out_is_node = r_out_is_node;
  assign o_done          = (r_fsm == DONE);
endmodule
